instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch stage upstream of instr_parse. Holds the PC and issues word reads to instruction memory
//  over a req/ack handshake with variable latency. Buffers returned words in a small prefetch FIFO.
//  Presents {instruction, pc} to decode with a valid/ready handshake. Branch redirect flushes all in flight.
// PARAMETERS
//  ADDR_W     64    PC / imem address width (bits)
//  FIFO_DEPTH 4     prefetch entries, power of 2, >=2
//  RESET_PC   64'h0 PC value after reset
// PORTS
//  clk            in   1          single clock, rising edge
//  reset          in   1          synchronous, active-high
//  imem_req       out  1          read request; held high until imem_ack
//  imem_addr      out  ADDR_W     word address of request; stable while imem_req
//  imem_ack       in   1          one-cycle pulse, imem_rdata valid this cycle
//  imem_rdata     in   INSTR_LEN  fetched instruction word
//  branch_taken   in   1          redirect pulse from execute
//  branch_target  in   ADDR_W     redirect PC; bits [1:0] forced to 0
//  decode_ready   in   1          decode accepts head entry this cycle
//  instr_valid    out  1          FIFO head valid
//  instruction    out  INSTR_LEN  FIFO head word
//  instr_pc       out  ADDR_W     PC of FIFO head word
// BEHAVIOUR
//  Reset (sync, active-high): pc=RESET_PC, FIFO empty, state=IDLE. Outputs: imem_req=0, instr_valid=0,
//   instruction=0, instr_pc=0. Reset mid-request drops the outstanding request; an ack in the same cycle is ignored.
//  FSM states:
//   IDLE  -> REQ when (count + 0) < FIFO_DEPTH and no redirect.
//   REQ   : imem_req=1, imem_addr=pc.
//           On ack: push {rdata, pc}; pc += 4; -> REQ if room remains after push, else IDLE.
//   FLUSH : imem_req=1 (handshake completes), next ack discarded; -> IDLE.
//  At most one outstanding request. Push happens only when room exists, so FIFO never overflows.
//  Latency: instr_valid rises the cycle after the first imem_ack. Best case is 1 instr/cycle with single-cycle ack.
//  Pop when instr_valid & decode_ready. Push and pop in the same cycle at full is legal; count is unchanged.
//  Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits.
//  branch_taken (highest priority except reset):
//   - FIFO cleared next cycle; the same-cycle pop still counts as accepted.
//   - pc = {branch_target[ADDR_W-1:2], 2'b00}.
//   - If in REQ without ack -> FLUSH. If ack arrives in the same cycle -> data dropped, -> IDLE.
//   - Redirect while in FLUSH stays in FLUSH with the new pc.
//  instr_valid is never asserted for a discarded word. Outputs are from registers (no comb path rdata->instruction).
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both 0 on reset.
//   fetch_cnt counts accepted pops. stall_cnt counts cycles with decode_ready & !instr_valid. Both saturate at all ones.
//  Undefined: ports and counters are absent; remaining behaviour is identical.
// STRUCTURE
//  fetch_pkg: fetch_state_e {IDLE,REQ,FLUSH}; typedef fetch_entry_t {instruction, pc}; PC_INC=4.
//  Sub-module fetch_fifo: parameterised sync FIFO of fetch_entry_t with push/pop/flush/count.
//  INSTR_LEN comes from the shared defines.
// TESTING
//  1 Reset, ack 1 cycle after each req, decode_ready=1:
//    imem_addr sequence 0,4,8,...; words F84F02C9, 8B0902AA, F80402EA appear in order with instr_pc 0, 4, 8.
//  2 decode_ready=0, ack every cycle:
//    exactly 4 requests, then imem_req=0. Raise decode_ready -> 4 pops in order, fetch resumes at pc 0x10.
//  3 Request to 0x8 outstanding, branch_taken target 0x103, ack 3 cycles later:
//    that word is dropped; next imem_addr=0x100; FIFO empty the cycle after the redirect.
//  4 branch_taken in the same cycle as imem_ack:
//    acked word never valid; next request at target.
//  5 Reset asserted while imem_req=1 and FIFO holds 2 entries:
//    next cycle instr_valid=0, imem_req=0, pc=RESET_PC.
//  6 FETCH_PERF_CNT_EN: 5 pops and 3 starved cycles -> fetch_cnt=5, stall_cnt=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
  localparam int INSTR_LEN = 32;
  localparam int PC_W = 64;
  localparam int PC_INC = 4;
  typedef enum logic [1:0] {IDLE, REQ, FLUSH} fetch_state_e;
  typedef struct packed {
    logic [INSTR_LEN-1:0] instruction;
    logic [PC_W-1:0]      pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of fetch entries with flush and occupancy count
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  fetch_entry_t din_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t dout_o,
  output logic [CW-1:0] count_o
);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk)
    if (reset || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  assign dout_o = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC + imem req/ack fetch FSM feeding a prefetch FIFO toward decode.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_cnt/stall_cnt outputs.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic                 imem_ack,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  input  logic                 branch_taken,
  input  logic [ADDR_W-1:0]    branch_target,
  input  logic                 decode_ready,
  output logic                 instr_valid,
  output logic [INSTR_LEN-1:0] instruction,
  output logic [ADDR_W-1:0]    instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          fetch_cnt,
  output logic [31:0]          stall_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);
  fetch_state_e state_q;
  logic [ADDR_W-1:0] pc_q, addr_q, target;
  logic req_q, push, pop, room;
  logic [CW-1:0] count;
  fetch_entry_t head;
  assign target = branch_target & ~ADDR_W'(3);
  assign pop = instr_valid && decode_ready;
  assign push = state_q == REQ && imem_ack && !branch_taken;
  assign room = (count + CW'(1) - CW'(pop)) < DEPTH_C;
  // addr_q freezes the in-flight address so a redirect during FLUSH keeps imem_addr stable
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      req_q <= 1'b0;
    end else if (branch_taken) begin
      pc_q <= target;
      state_q <= req_q && !imem_ack ? FLUSH : IDLE;
      req_q <= req_q && !imem_ack;
    end else
      case (state_q)
        IDLE: if (count < DEPTH_C) begin
          state_q <= REQ;
          req_q <= 1'b1;
          addr_q <= pc_q;
        end
        REQ: if (imem_ack) begin
          pc_q <= pc_q + INC;
          addr_q <= pc_q + INC;
          state_q <= room ? REQ : IDLE;
          req_q <= room;
        end
        FLUSH: if (imem_ack) begin
          state_q <= IDLE;
          req_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   ('{instruction: imem_rdata, pc: PC_W'(pc_q)}),
    .pop_i   (pop),
    .flush_i (branch_taken),
    .dout_o  (head),
    .count_o (count)
  );
  assign imem_req = req_q;
  assign imem_addr = addr_q;
  assign instr_valid = count != '0;
  assign instruction = instr_valid ? head.instruction : '0;
  assign instr_pc = instr_valid ? head.pc[ADDR_W-1:0] : '0;
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk)
    if (reset) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && !(&fetch_cnt)) fetch_cnt <= fetch_cnt + 32'd1;
      if (decode_ready && !instr_valid && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule
